// File: rtl/cpu_defs.sv
// Shared CPU types and constants for the fetch front end.
// Covers the flush and branch buses, the exception record, and the boot/exception vectors.
package cpu_defs;

    typedef logic [31:0] virt_t;

    localparam virt_t ResetVec  = 32'hBFC0_0000;
    localparam virt_t RefillVec = 32'hBFC0_0200;
    localparam virt_t ExcVec    = 32'hBFC0_0380;

    localparam logic [4:0] ExcInt  = 5'h00;
    localparam logic [4:0] ExcAdEL = 5'h04;
    localparam logic [4:0] ExcAdES = 5'h05;

    typedef struct packed {
        logic  br_op;
        logic  br_taken;
        virt_t br_target;
    } br_bus_t;

    typedef struct packed {
        logic ex;
        logic eret;
        logic tlb_op;
        logic refill;
    } pipeline_flush_t;

    typedef struct packed {
        logic       ex;
        logic       tlb_refill;
        logic [4:0] exccode;
        virt_t      badvaddr;
    } exception_t;

    typedef struct packed {
        logic       valid;
        logic       req;
        logic       br_op;
        virt_t      pc;
        exception_t exception;
    } pfs_to_fs_bus_t;

    function automatic logic is_flush(pipeline_flush_t f);
        return f.ex | f.eret | f.tlb_op | f.refill;
    endfunction

endpackage

// File: rtl/pfs_npc_sel.sv
// Next-PC priority mux for the pre-IF stage; purely combinational.
// Holds the current PC when nothing redirects it and no transfer happens.
module pfs_npc_sel
    import cpu_defs::*;
(
    input  virt_t           pc_i,
    input  pipeline_flush_t flush_i,
    input  virt_t           c0_epc_i,
    input  virt_t           tlb_refetch_pc_i,
    input  logic            bpu_flush_i,
    input  virt_t           bpu_target_i,
    input  logic            br_sel_i,
    input  virt_t           br_target_i,
    input  logic            advance_i,
    output virt_t           npc_o
);

    virt_t seq_pc;

    assign seq_pc = pc_i + 32'd4;

    always_comb begin
        npc_o = pc_i;
        if (flush_i.refill) begin
            npc_o = RefillVec;
        end else if (flush_i.ex) begin
            npc_o = ExcVec;
        end else if (flush_i.eret) begin
            npc_o = c0_epc_i;
        end else if (flush_i.tlb_op) begin
            npc_o = tlb_refetch_pc_i;
        end else if (bpu_flush_i) begin
            npc_o = bpu_target_i;
        end else if (br_sel_i) begin
            npc_o = br_target_i;
        end else if (advance_i) begin
            npc_o = seq_pc;
        end
    end

endmodule

// File: rtl/pre_if_stage.sv
// Pre-IF stage: owns the fetch PC, issues icache requests and hands PCs to IF.
// Tracks an accepted-but-not-transferred request and a branch waiting on its delay slot.
module pre_if_stage
    import cpu_defs::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            fs_allowin_i,
    input  logic            fs_valid_i,
    input  br_bus_t         br_bus_i,
    input  logic            bpu_flush_i,
    input  virt_t           bpu_target_i,
    input  pipeline_flush_t pipeline_flush_i,
    input  virt_t           c0_epc_i,
    input  virt_t           tlb_refetch_pc_i,
    output logic            icache_req_o,
    output virt_t           icache_addr_o,
    input  logic            icache_addr_ok_i,
    output pfs_to_fs_bus_t  pfs_to_fs_bus_o
);

    virt_t pc_q, pc_d;
    logic  pc_valid_q;
    logic  accepted_q, accepted_d;
    logic  br_pend_q, br_pend_d;
    virt_t br_target_q, br_target_d;

    logic  flush_any;
    logic  br_in;
    logic  br_now;
    logic  br_new;
    logic  redirect;
    logic  adel;
    logic  addr_hs;
    logic  ready_go;
    logic  pfs_valid;
    logic  transfer;
    logic  br_sel;
    virt_t br_tgt;

    assign flush_any = is_flush(pipeline_flush_i);
    assign br_in     = br_bus_i.br_op & br_bus_i.br_taken;
    // IF already holding an instruction means the delay slot has left this stage
    assign br_now    = br_in & fs_valid_i;
    assign br_new    = br_in & ~fs_valid_i;
    assign redirect  = flush_any | bpu_flush_i | br_now;

    assign adel          = pc_valid_q & (pc_q[1:0] != 2'b00);
    assign icache_req_o  = pc_valid_q & ~accepted_q & ~adel & ~redirect;
    assign icache_addr_o = pc_q;
    assign addr_hs       = icache_req_o & icache_addr_ok_i;
    assign ready_go      = addr_hs | accepted_q | adel;

    // A BPU redirect still lets an already-fetched delay slot leave if IF can take it
    assign pfs_valid = ready_go & ~flush_any & ~br_now & (~bpu_flush_i | fs_allowin_i);
    assign transfer  = pfs_valid & fs_allowin_i;

    assign br_sel = br_now | (transfer & (br_pend_q | br_new));
    assign br_tgt = br_in ? br_bus_i.br_target : br_target_q;

    pfs_npc_sel u_npc_sel (
        .pc_i             (pc_q),
        .flush_i          (pipeline_flush_i),
        .c0_epc_i         (c0_epc_i),
        .tlb_refetch_pc_i (tlb_refetch_pc_i),
        .bpu_flush_i      (bpu_flush_i),
        .bpu_target_i     (bpu_target_i),
        .br_sel_i         (br_sel),
        .br_target_i      (br_tgt),
        .advance_i        (transfer),
        .npc_o            (pc_d)
    );

    always_comb begin
        accepted_d  = accepted_q;
        br_pend_d   = br_pend_q;
        br_target_d = br_target_q;
        if (redirect || transfer) begin
            accepted_d = 1'b0;
            br_pend_d  = 1'b0;
        end else begin
            if (addr_hs && !fs_allowin_i) begin
                accepted_d = 1'b1;
            end
            if (br_new) begin
                br_pend_d = 1'b1;
            end
        end
        if (br_new) begin
            br_target_d = br_bus_i.br_target;
        end
    end

    always_comb begin
        pfs_to_fs_bus_o = '0;
        if (pc_valid_q) begin
            pfs_to_fs_bus_o.valid              = pfs_valid;
            pfs_to_fs_bus_o.req                = addr_hs;
            pfs_to_fs_bus_o.br_op              = br_pend_q | br_new;
            pfs_to_fs_bus_o.pc                 = pc_q;
            pfs_to_fs_bus_o.exception.ex       = adel;
            pfs_to_fs_bus_o.exception.exccode  = adel ? ExcAdEL : ExcInt;
            pfs_to_fs_bus_o.exception.badvaddr = adel ? pc_q : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= ResetVec;
            pc_valid_q  <= 1'b0;
            accepted_q  <= 1'b0;
            br_pend_q   <= 1'b0;
            br_target_q <= '0;
        end else begin
            pc_q        <= pc_d;
            pc_valid_q  <= 1'b1;
            accepted_q  <= accepted_d;
            br_pend_q   <= br_pend_d;
            br_target_q <= br_target_d;
        end
    end

endmodule

// File: tb/tb_pre_if_stage.sv
// Bench for pre_if_stage: directed scenarios plus a randomized run against a fetch-stream model.
module tb_pre_if_stage;
    import cpu_defs::*;

    logic            clk = 1'b0;
    logic            reset;
    logic            fs_allowin;
    logic            fs_valid;
    br_bus_t         br_bus;
    logic            bpu_flush;
    virt_t           bpu_target;
    pipeline_flush_t pflush;
    virt_t           c0_epc;
    virt_t           tlb_refetch_pc;
    logic            icache_req;
    virt_t           icache_addr;
    logic            icache_addr_ok;
    pfs_to_fs_bus_t  bus;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pre_if_stage dut (
        .clk              (clk),
        .reset            (reset),
        .fs_allowin_i     (fs_allowin),
        .fs_valid_i       (fs_valid),
        .br_bus_i         (br_bus),
        .bpu_flush_i      (bpu_flush),
        .bpu_target_i     (bpu_target),
        .pipeline_flush_i (pflush),
        .c0_epc_i         (c0_epc),
        .tlb_refetch_pc_i (tlb_refetch_pc),
        .icache_req_o     (icache_req),
        .icache_addr_o    (icache_addr),
        .icache_addr_ok_i (icache_addr_ok),
        .pfs_to_fs_bus_o  (bus)
    );

    task automatic clear_events();
        br_bus    = '0;
        bpu_flush = 1'b0;
        pflush    = '0;
        fs_valid  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; fs_allowin = 1'b1; icache_addr_ok = 1'b1;
        c0_epc = '0; tlb_refetch_pc = '0; bpu_target = '0;
        clear_events();
        @(negedge clk); @(negedge clk); #1;
        n_cmp++; if (icache_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %0b want 0", icache_req); end
        n_cmp++; if (bus !== '0) begin n_err++; $display("FAIL reset_bus: got %h want 0", bus); end
        @(negedge clk); reset = 1'b0; #1;
        n_cmp++; if (icache_req !== 1'b0) begin n_err++; $display("FAIL release_req: got %0b want 0", icache_req); end
        n_cmp++; if (icache_addr !== 32'hBFC00000) begin n_err++; $display("FAIL release_addr: got %h want bfc00000", icache_addr); end
    endtask

    task automatic test_seq_fetch();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_cmp++; if (icache_req !== 1'b1) begin n_err++; $display("FAIL seq_req[%0d]: got %0b want 1", i, icache_req); end
            n_cmp++; if (icache_addr !== 32'hBFC00000 + 32'(4 * i)) begin n_err++; $display("FAIL seq_addr[%0d]: got %h want %h", i, icache_addr, 32'hBFC00000 + 32'(4 * i)); end
            n_cmp++; if (bus.valid !== 1'b1) begin n_err++; $display("FAIL seq_valid[%0d]: got %0b want 1", i, bus.valid); end
        end
    endtask

    task automatic test_stall();
        int reqs = 0;
        @(negedge clk); #1;
        n_cmp++; if (icache_addr !== 32'hBFC0000C) begin n_err++; $display("FAIL stall_pre_addr: got %h want bfc0000c", icache_addr); end
        @(negedge clk); fs_allowin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (icache_req) reqs++;
            n_cmp++; if (icache_addr !== 32'hBFC00010) begin n_err++; $display("FAIL stall_addr[%0d]: got %h want bfc00010", i, icache_addr); end
            n_cmp++; if (bus.valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d]: got %0b want 1", i, bus.valid); end
        end
        n_cmp++; if (reqs !== 1) begin n_err++; $display("FAIL stall_reqs: got %0d want 1", reqs); end
        @(negedge clk); fs_allowin = 1'b1; #1;
        n_cmp++; if ({bus.valid, icache_req, bus.pc} !== {2'b10, 32'hBFC00010}) begin n_err++; $display("FAIL stall_release: got %0b%0b %h want 10 bfc00010", bus.valid, icache_req, bus.pc); end
        @(negedge clk); #1;
        n_cmp++; if (icache_addr !== 32'hBFC00014) begin n_err++; $display("FAIL stall_next: got %h want bfc00014", icache_addr); end
    endtask

    task automatic test_branch_pending();
        repeat (3) @(negedge clk);
        @(negedge clk);
        br_bus = '{br_op: 1'b1, br_taken: 1'b1, br_target: 32'h80001000};
        icache_addr_ok = 1'b0; #1;
        n_cmp++; if ({icache_addr, bus.br_op, bus.valid} !== {32'hBFC00024, 2'b10}) begin n_err++; $display("FAIL br_arrive: got %h br_op=%0b valid=%0b want bfc00024 1 0", icache_addr, bus.br_op, bus.valid); end
        @(negedge clk); br_bus = '0; icache_addr_ok = 1'b1; #1;
        n_cmp++; if ({bus.pc, bus.br_op, bus.valid} !== {32'hBFC00024, 2'b11}) begin n_err++; $display("FAIL br_slot: got %h br_op=%0b valid=%0b want bfc00024 1 1", bus.pc, bus.br_op, bus.valid); end
        @(negedge clk); #1;
        n_cmp++; if ({icache_addr, bus.br_op} !== {32'h80001000, 1'b0}) begin n_err++; $display("FAIL br_target: got %h br_op=%0b want 80001000 0", icache_addr, bus.br_op); end
    endtask

    task automatic test_flushes();
        @(negedge clk);
        pflush.ex = 1'b1;
        br_bus = '{br_op: 1'b1, br_taken: 1'b1, br_target: 32'h80002000}; #1;
        n_cmp++; if ({icache_req, bus.valid} !== 2'b00) begin n_err++; $display("FAIL ex_cycle: got req=%0b valid=%0b want 0 0", icache_req, bus.valid); end
        @(negedge clk); clear_events(); #1;
        n_cmp++; if ({icache_addr, icache_req, bus.br_op} !== {32'hBFC00380, 2'b10}) begin n_err++; $display("FAIL ex_vec: got %h req=%0b br_op=%0b want bfc00380 1 0", icache_addr, icache_req, bus.br_op); end
        @(negedge clk); #1;
        n_cmp++; if (icache_addr !== 32'hBFC00384) begin n_err++; $display("FAIL ex_no_br: got %h want bfc00384", icache_addr); end
        @(negedge clk); pflush.eret = 1'b1; c0_epc = 32'h80000100; #1;
        n_cmp++; if (icache_req !== 1'b0) begin n_err++; $display("FAIL eret_req: got %0b want 0", icache_req); end
        @(negedge clk); clear_events(); #1;
        n_cmp++; if (icache_addr !== 32'h80000100) begin n_err++; $display("FAIL eret_addr: got %h want 80000100", icache_addr); end
        @(negedge clk); pflush.refill = 1'b1;
        @(negedge clk); clear_events(); #1;
        n_cmp++; if (icache_addr !== 32'hBFC00200) begin n_err++; $display("FAIL refill_addr: got %h want bfc00200", icache_addr); end
        @(negedge clk); pflush.tlb_op = 1'b1; tlb_refetch_pc = 32'h90000040;
        @(negedge clk); clear_events(); #1;
        n_cmp++; if (icache_addr !== 32'h90000040) begin n_err++; $display("FAIL tlb_addr: got %h want 90000040", icache_addr); end
    endtask

    task automatic test_bpu_adel();
        @(negedge clk); fs_allowin = 1'b0; bpu_flush = 1'b1; bpu_target = 32'h80000002; #1;
        n_cmp++; if (icache_req !== 1'b0) begin n_err++; $display("FAIL bpu_req: got %0b want 0", icache_req); end
        @(negedge clk); clear_events(); #1;
        n_cmp++; if ({icache_req, bus.valid, bus.exception.ex} !== 3'b011) begin n_err++; $display("FAIL adel_flags: got req=%0b valid=%0b ex=%0b want 0 1 1", icache_req, bus.valid, bus.exception.ex); end
        n_cmp++; if (bus.exception.exccode !== 5'h04) begin n_err++; $display("FAIL adel_code: got %h want 04", bus.exception.exccode); end
        n_cmp++; if (bus.exception.badvaddr !== 32'h80000002) begin n_err++; $display("FAIL adel_badva: got %h want 80000002", bus.exception.badvaddr); end
        // delay slot already accepted leaves together with a BPU redirect
        @(negedge clk); bpu_flush = 1'b1; bpu_target = 32'h80000200;
        @(negedge clk); clear_events(); #1;
        n_cmp++; if (icache_req !== 1'b1) begin n_err++; $display("FAIL bpu2_req: got %0b want 1", icache_req); end
        @(negedge clk); fs_allowin = 1'b1; bpu_flush = 1'b1; bpu_target = 32'h80000400; #1;
        n_cmp++; if ({bus.valid, bus.pc} !== {1'b1, 32'h80000200}) begin n_err++; $display("FAIL bpu_slot: got valid=%0b %h want 1 80000200", bus.valid, bus.pc); end
        @(negedge clk); clear_events(); fs_allowin = 1'b0; #1;
        n_cmp++; if ({icache_addr, icache_req} !== {32'h80000400, 1'b1}) begin n_err++; $display("FAIL bpu_next: got %h req=%0b want 80000400 1", icache_addr, icache_req); end
    endtask

    task automatic test_reset_mid_stall();
        @(negedge clk); #1;
        n_cmp++; if ({icache_req, bus.valid} !== 2'b01) begin n_err++; $display("FAIL acc_before_reset: got req=%0b valid=%0b want 0 1", icache_req, bus.valid); end
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0; #1;
        n_cmp++; if ({icache_req, icache_addr} !== {1'b0, 32'hBFC00000}) begin n_err++; $display("FAIL rst_stall: got req=%0b %h want 0 bfc00000", icache_req, icache_addr); end
        n_cmp++; if (bus !== '0) begin n_err++; $display("FAIL rst_stall_bus: got %h want 0", bus); end
        @(negedge clk); #1;
        n_cmp++; if ({icache_req, icache_addr} !== {1'b1, 32'hBFC00000}) begin n_err++; $display("FAIL rst_rereq: got req=%0b %h want 1 bfc00000", icache_req, icache_addr); end
    endtask

    // Model: the stream of PCs IF must receive, one handshake per PC, redirects per priority.
    task automatic test_random();
        virt_t exp_pc = 32'hBFC00000;
        virt_t ptgt   = '0;
        virt_t tgt;
        bit    pend   = 1'b0;
        int    hs_cnt = 0;
        int    n_xfer = 0;
        int    ev;
        logic  xfer;
        @(negedge clk); reset = 1'b1; clear_events();
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            clear_events();
            fs_allowin     = ($urandom_range(0, 3) != 0);
            icache_addr_ok = 1'($urandom_range(0, 1));
            fs_valid       = 1'($urandom_range(0, 1));
            tgt            = {4'h8, 26'($urandom), 2'b00};
            br_bus.br_target = tgt; bpu_target = tgt; c0_epc = tgt; tlb_refetch_pc = tgt;
            ev = int'($urandom_range(0, 99));
            if (ev < 2) pflush.ex = 1'b1;
            else if (ev < 4) pflush.eret = 1'b1;
            else if (ev < 6) pflush.tlb_op = 1'b1;
            else if (ev < 8) pflush.refill = 1'b1;
            else if (ev < 13) bpu_flush = 1'b1;
            else if (ev < 20) begin br_bus.br_op = 1'b1; br_bus.br_taken = 1'b1; end
            else if (ev < 23) br_bus.br_op = 1'b1;
            #1;
            if (icache_req) begin
                n_cmp++; if (icache_addr !== exp_pc) begin n_err++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, icache_addr, exp_pc); end
                if (icache_addr_ok) hs_cnt++;
            end
            xfer = bus.valid & fs_allowin;
            if (ev < 8) begin
                n_cmp++; if ({icache_req, bus.valid} !== 2'b00) begin n_err++; $display("FAIL rnd_flush[%0d]: got req=%0b valid=%0b want 0 0", i, icache_req, bus.valid); end
                exp_pc = (ev < 2) ? 32'hBFC00380 : (ev < 6) ? tgt : 32'hBFC00200;
                pend = 1'b0; hs_cnt = 0;
            end else if (ev >= 13 && ev < 20 && fs_valid) begin
                n_cmp++; if (bus.valid !== 1'b0) begin n_err++; $display("FAIL rnd_brnow[%0d]: got valid=%0b want 0", i, bus.valid); end
                exp_pc = tgt; pend = 1'b0; hs_cnt = 0;
            end else begin
                if (ev >= 13 && ev < 20) begin pend = 1'b1; ptgt = tgt; end
                if (xfer) begin
                    n_xfer++;
                    n_cmp++; if (bus.pc !== exp_pc) begin n_err++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, bus.pc, exp_pc); end
                    n_cmp++; if (bus.br_op !== pend) begin n_err++; $display("FAIL rnd_brop[%0d]: got %0b want %0b", i, bus.br_op, pend); end
                    n_cmp++; if (hs_cnt !== 1) begin n_err++; $display("FAIL rnd_reqs[%0d]: got %0d want 1", i, hs_cnt); end
                    hs_cnt = 0;
                    if (pend) begin exp_pc = ptgt; pend = 1'b0; end
                    else exp_pc = exp_pc + 32'd4;
                end
                if (ev >= 8 && ev < 13) begin
                    n_cmp++; if (icache_req !== 1'b0) begin n_err++; $display("FAIL rnd_bpu_req[%0d]: got %0b want 0", i, icache_req); end
                    exp_pc = tgt; pend = 1'b0; hs_cnt = 0;
                end
            end
        end
        n_cmp++; if (n_xfer < 100) begin n_err++; $display("FAIL rnd_progress: got %0d transfers want >= 100", n_xfer); end
    endtask

    initial begin
        test_reset();
        test_seq_fetch();
        test_stall();
        test_branch_pending();
        test_flushes();
        test_bpu_adel();
        test_reset_mid_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
